// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/sequencing controller.
// master: datapath side (drives hazard inputs); slave: controller side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic             ResultSrcE0;
  logic             PCSrcE;
  logic [4:0]       RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic             MemReqM, MemReadyM;
  logic             EnF, EnD, EnE, EnM, EnW;
  logic             FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount, RedirectCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  EnF, EnD, EnE, EnM, EnW, FlushD, FlushE,
           ForwardAE, ForwardBE, MemTimeout, StallCount, RedirectCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output EnF, EnD, EnE, EnM, EnW, FlushD, FlushE,
           ForwardAE, ForwardBE, MemTimeout, StallCount, RedirectCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: boot NOP-fill, memory freeze, redirect/load-use
// handling, E-stage forwarding select and saturating performance counters.
//
// state   | meaning
// BOOT    | after reset: fetch held, D/E flushed for BOOT_CYCLES edges
// RUN     | normal issue; redirect / load-use / freeze resolved combinationally
// MEMWAIT | data-memory access outstanding, whole pipeline frozen
module pipe_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int BOOT_LAST = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
  localparam int WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [BOOT_W-1:0]  boot_cnt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic               timeout_q;
  logic [CNT_W-1:0]   stall_cnt, redirect_cnt;

  logic running, freeze, load_use, redirect, lu_stall, boot_done, timeout_set;

  assign running   = (state_q != BOOT);
  assign freeze    = running & hz.MemReqM & ~hz.MemReadyM;
  assign load_use  = hz.ResultSrcE0 & (hz.RdE != 5'd0) &
                     ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
  // Redirect wins over load-use: the stalled D instruction is discarded anyway.
  assign redirect  = running & ~freeze & hz.PCSrcE;
  assign lu_stall  = running & ~freeze & ~hz.PCSrcE & load_use;
  assign boot_done = (boot_cnt == BOOT_W'(BOOT_LAST));

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      BOOT:    if (boot_done) state_nxt = RUN;
      RUN:     if (freeze)    state_nxt = MEMWAIT;
      MEMWAIT: if (!freeze)   state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    hz.EnF    = 1'b1;
    hz.EnD    = 1'b1;
    hz.EnE    = 1'b1;
    hz.EnM    = 1'b1;
    hz.EnW    = 1'b1;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    if (!running) begin
      hz.EnF    = 1'b0;
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (freeze) begin
      hz.EnF = 1'b0;
      hz.EnD = 1'b0;
      hz.EnE = 1'b0;
      hz.EnM = 1'b0;
      hz.EnW = 1'b0;
    end else if (redirect) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (lu_stall) begin
      hz.EnF    = 1'b0;
      hz.EnD    = 1'b0;
      hz.FlushE = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

  always_comb begin
    wait_nxt = '0;
    if (freeze) begin
      wait_nxt = (wait_cnt == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
    end
  end

  assign timeout_set = freeze && (MEM_TIMEOUT != 0) && (wait_nxt == WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      boot_cnt     <= '0;
      wait_cnt     <= '0;
      timeout_q    <= 1'b0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_q == BOOT && !boot_done) boot_cnt <= boot_cnt + BOOT_W'(1);
      if (timeout_set) timeout_q <= 1'b1;
      if ((freeze || lu_stall) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

  assign hz.MemTimeout    = timeout_q;
  assign hz.StallCount    = stall_cnt;
  assign hz.RedirectCount = redirect_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central sequencing controller for the five-stage RISC-V pipeline. It drives the enable/flush pins of the F/D/E/M/W stage registers and the E-stage forwarding muxes. It also runs a post-reset NOP-fill sequence and freezes the pipeline during multi-cycle data-memory accesses. It keeps saturating stall/redirect counters for performance inspection.

## Interface
- BOOT_CYCLES, 4: cycles after reset release during which D/E are flushed and fetch is held (0 = skip).
- MEM_TIMEOUT, 64: consecutive freeze cycles that set MemTimeout (0 = disabled).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5  source/destination registers of the instruction in E.
- ResultSrcE0  in  1  instruction in E is a load.
- PCSrcE  in  1  taken branch/jump resolved in E.
- RdM, RdW  in  5  destination registers in M and W.
- RegWriteM, RegWriteW  in  1  M / W write the register file.
- MemReqM  in  1  M performs a data-memory access.
- MemReadyM  in  1  data memory completes the access this cycle.
- EnF, EnD, EnE, EnM, EnW  out  1  stage-register enables (EnF gates the PC register).
- FlushD, FlushE  out  1  load NOP (0x00000013) into D / E; only effective with the matching enable.
- ForwardAE, ForwardBE  out  2  00 register file, 01 from W, 10 from M.
- MemTimeout  out  1  sticky timeout flag.
- StallCount, RedirectCount  out  CNT_W  saturating counters.

## Operation
- State register with 3 states: BOOT, RUN, MEMWAIT. Also boot_cnt, wait_cnt, and the counters.
- BOOT: EnF=0, EnD=EnE=EnM=EnW=1, FlushD=FlushE=1. PCSrcE, load-use and MemReqM are ignored.
  - Leave BOOT after BOOT_CYCLES rising edges following reset release, going to RUN.
  - BOOT_CYCLES=0: the first edge after release already lands in RUN.
- freeze = MemReqM & ~MemReadyM, evaluated in RUN/MEMWAIT.
  - While frozen, all En*=0 and FlushD=FlushE=0.
  - RUN to MEMWAIT on an edge with freeze=1. MEMWAIT to RUN on an edge with freeze=0.
- Priority when not frozen, in RUN/MEMWAIT:
  - Redirect: PCSrcE=1 gives FlushD=1, FlushE=1, all enables 1.
  - Load-use stall: ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D). Gives EnF=0, EnD=0, FlushE=1, EnE=EnM=EnW=1.
  - Otherwise all enables 1 and flushes 0.
  - Redirect and load-use together (illegal) are resolved as redirect, with no stall.
- Forwarding is combinational in all states:
  - ForwardAE=10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - Else 00.
  - M beats W on a match to both. ForwardBE is the same using Rs2E.
- wait_cnt:
  - Cleared whenever freeze=0; increments each frozen cycle, saturating at MEM_TIMEOUT.
  - MemTimeout sets on the edge at which wait_cnt reaches MEM_TIMEOUT (MEM_TIMEOUT≠0).
  - The freeze itself continues; MemTimeout clears only on reset.
- StallCount +1 per cycle, outside BOOT, in which freeze or load-use stall is applied.
- RedirectCount +1 per cycle, outside BOOT, in which a redirect is applied (not while frozen).
- Both counters hold at 2^CNT_W−1.

## Timing
- reset_n low, immediately and asynchronously:
  - state=BOOT, boot_cnt=0, wait_cnt=0, MemTimeout=0, counters=0.
  - Outputs take their BOOT values; forwarding stays combinational.
- Reset asserted in MEMWAIT: the same values apply, no completion is awaited, and the pending access is abandoned.
- All En*/Flush*/Forward* are combinational from current inputs and state, valid in the same cycle. There is no added latency.
- Load-use costs exactly 1 bubble: the next cycle has the load in M and the stall condition false.
- A redirect discards exactly 2 instructions (D and E).
- An access with MemReadyM on its first M cycle causes no freeze and no state change.
- A redirect held in E during a freeze is applied on the first unfrozen cycle.

## Test plan
- Reset release with BOOT_CYCLES=4:
  - Cycles 0–3 give EnF=0, FlushD=FlushE=1.
  - Cycle 4 gives all En=1, flushes 0, and D then holds 0x13.
- Load in E with RdE=5 and Rs2D=5: one cycle of EnF=0, EnD=0, FlushE=1; StallCount=1.
  - Repeat with RdE=0: no stall.
- PCSrcE=1 for one cycle: FlushD=FlushE=1 that cycle, RedirectCount=1.
  - With PCSrcE and a load-use match both forced: redirect outputs, StallCount unchanged.
- MemReqM=1 with MemReadyM=0 for 3 cycles, then 1:
  - 3 cycles all En=0 and flushes 0, with state MEMWAIT from the 2nd cycle; StallCount=3; back to RUN.
- MEM_TIMEOUT=4 with MemReadyM low for 6 cycles:
  - MemTimeout rises after the 4th frozen edge and stays 1 after MemReadyM=1.
  - It clears only when reset_n is pulsed low mid-freeze, and BOOT restarts.
- RdM=RdW=Rs1E=7 with RegWriteM=RegWriteW=1: ForwardAE=10.
  - With RegWriteM=0: 01.
  - With Rs1E=0: 00.
